ram_port_arbiter: RTL and testbench

//  Shares the single data port (port B) of RAM_mem between two bus masters: m0 = RS5 data port, m1 = accelerator/DMA master.

---
 rtl/ram_port_arbiter_pkg.sv | 13 +
 rtl/ram_port_arbiter_stats.sv | 40 ++++
 rtl/ram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port-B arbiter.
// Owner encoding for the read-return path and the default hold limit.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_owner_e;

    localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/ram_port_arbiter_stats.sv
// arb_stats: grant and conflict counters for the RAM port arbiter.
// Built only when ARB_STATS_EN is defined; counters wrap at 2^32.
module arb_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_gnt_i,
    input  logic        m1_gnt_i,
    input  logic        conflict_i,
    output logic [31:0] m0_cnt_o,
    output logic [31:0] m1_cnt_o,
    output logic [31:0] conflict_cnt_o
);

    logic [31:0] m0_cnt_q, m0_cnt_d;
    logic [31:0] m1_cnt_q, m1_cnt_d;
    logic [31:0] cf_cnt_q, cf_cnt_d;

    always_comb begin
        m0_cnt_d = m0_cnt_q + {31'd0, m0_gnt_i};
        m1_cnt_d = m1_cnt_q + {31'd0, m1_gnt_i};
        cf_cnt_d = cf_cnt_q + {31'd0, conflict_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_cnt_q <= '0;
            m1_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            m0_cnt_q <= m0_cnt_d;
            m1_cnt_q <= m1_cnt_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    assign m0_cnt_o       = m0_cnt_q;
    assign m1_cnt_o       = m1_cnt_q;
    assign conflict_cnt_o = cf_cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for RAM_mem port B: m0 priority, m1 forced in after MAX_HOLD.
// Optional grant statistics when ARB_STATS_EN is defined.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_m0_cnt,
    output logic [31:0]         stat_m1_cnt,
    output logic [31:0]         stat_conflict_cnt
`endif
);

    localparam int WE_W   = DATA_W / 8;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    arb_owner_e        rd_owner_q, rd_owner_d;
    logic              force_m1;
    logic              gnt0, gnt1;

    assign force_m1 = (hold_q == HOLD_W'(MAX_HOLD));

    // Grants are suppressed during reset so every output is quiet asynchronously.
    always_comb begin
        gnt0 = ~reset & m0_req & ~(m1_req & force_m1);
        gnt1 = ~reset & m1_req & ~gnt0;
    end

    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            gnt0: begin
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
            end
            gnt1: begin
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    assign mem_en = gnt0 | gnt1;
    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    always_comb begin
        hold_d = hold_q;
        if (gnt1 || !m1_req) begin
            hold_d = '0;
        end else if (gnt0 && !force_m1) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_comb begin
        rd_owner_d = ARB_NONE;
        if (gnt0 && m0_we == '0) begin
            rd_owner_d = ARB_M0;
        end else if (gnt1 && m1_we == '0) begin
            rd_owner_d = ARB_M1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            rd_owner_q <= ARB_NONE;
        end else begin
            hold_q     <= hold_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = (rd_owner_q == ARB_M0);
    assign m1_rvalid = (rd_owner_q == ARB_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    arb_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .m0_gnt_i       (gnt0),
        .m1_gnt_i       (gnt1),
        .conflict_i     (m0_req & m1_req & ~reset),
        .m0_cnt_o       (stat_m0_cnt),
        .m1_cnt_o       (stat_m1_cnt),
        .conflict_cnt_o (stat_conflict_cnt)
    );
`endif

    initial assert (WE_W * 8 == DATA_W && MAX_HOLD >= 1)
        else $error("bad arbiter parameters");

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter with a write-first synchronous RAM model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] stat_m0_cnt, stat_m1_cnt, stat_conflict_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_m0_cnt       (stat_m0_cnt),
        .stat_m1_cnt       (stat_m1_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
`endif
    );

    // Write-first synchronous RAM, 256 words
    logic [31:0] ram [0:255];
    logic [31:0] merged;

    always_comb begin
        merged = ram[mem_addr[7:0]];
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) merged[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            ram[mem_addr[7:0]] <= merged;
            mem_rdata          <= merged;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: read expectations come from a shadow of every granted write
    logic [31:0] shadow [logic [15:0]];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;

    function automatic logic [31:0] mrg(logic [31:0] old, logic [3:0] we,
                                        logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] peek(logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                q0.delete();
                q1.delete();
                pend0 = 1'b0;
                pend1 = 1'b0;
            end else begin
                check("m0_rvalid_lat", 32'(m0_rvalid), 32'(pend0));
                check("m1_rvalid_lat", 32'(m1_rvalid), 32'(pend1));
                if (m0_rvalid && q0.size() != 0) begin
                    check("m0_rdata_sb", m0_rdata, q0.pop_front());
                    check("m1_rdata_quiet", m1_rdata, 32'h0);
                end
                if (m1_rvalid && q1.size() != 0) begin
                    check("m1_rdata_sb", m1_rdata, q1.pop_front());
                    check("m0_rdata_quiet", m0_rdata, 32'h0);
                end
                pend0 = m0_gnt && (m0_we == 4'h0);
                pend1 = m1_gnt && (m1_we == 4'h0);
                if (pend0) q0.push_back(peek(m0_addr));
                if (pend1) q1.push_back(peek(m1_addr));
                if (m0_gnt && m0_we != 4'h0)
                    shadow[m0_addr] = mrg(peek(m0_addr), m0_we, m0_wdata);
                if (m1_gnt && m1_we != 4'h0)
                    shadow[m1_addr] = mrg(peek(m1_addr), m1_we, m1_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        reset    = 1'b1;
        m0_req   = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req   = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        reset = 1'b0;

        // Preload 0x0010 via an m0 write
        m0_req = 1'b1; m0_we = 4'hF; m0_addr = 16'h0010; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("pre_m0_gnt", 32'(m0_gnt), 32'h1);
        cyc();

        // Lone m0 read
        m0_we = 4'h0;
        @(negedge clk);
        check("t1_m0_gnt", 32'(m0_gnt), 32'h1);
        check("t1_m1_gnt", 32'(m1_gnt), 32'h0);
        check("t1_mem_en", 32'(mem_en), 32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0010);
        check("t1_mem_we", 32'(mem_we), 32'h0);
        cyc();
        m0_req = 1'b0;
        @(negedge clk);
        check("t1_m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("t1_m1_rvalid", 32'(m1_rvalid), 32'h0);
        cyc();

        // m1 write then m0 read of the same word
        m1_req = 1'b1; m1_we = 4'hF; m1_addr = 16'h0020; m1_wdata = 32'h12345678;
        @(negedge clk);
        check("t3_m1_gnt", 32'(m1_gnt), 32'h1);
        check("t3_m0_gnt", 32'(m0_gnt), 32'h0);
        check("t3_mem_we", 32'(mem_we), 32'hF);
        check("t3_mem_addr", 32'(mem_addr), 32'h0020);
        check("t3_mem_wdata", mem_wdata, 32'h12345678);
        cyc();
        m1_req = 1'b0; m1_we = 4'h0;
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 16'h0020;
        @(negedge clk);
        check("t3_m0_gnt", 32'(m0_gnt), 32'h1);
        check("t3_m1_rvalid_w", 32'(m1_rvalid), 32'h0);
        cyc();
        // Partial write, low half only
        m0_we = 4'b0011; m0_wdata = 32'hAAAA5555;
        @(negedge clk);
        check("t3_m0_rdata", m0_rdata, 32'h12345678);
        check("t3_m1_rvalid", 32'(m1_rvalid), 32'h0);
        check("pw_mem_we", 32'(mem_we), 32'h3);
        cyc();

        // m0 read at N, m1 read at N+1
        m0_we = 4'h0; m0_addr = 16'h0010;
        @(negedge clk);
        check("t4_m0_gnt", 32'(m0_gnt), 32'h1);
        cyc();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 4'h0; m1_addr = 16'h0020;
        @(negedge clk);
        check("t4_m1_gnt", 32'(m1_gnt), 32'h1);
        check("t4_m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("t4_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("t4_m1_rvalid_n1", 32'(m1_rvalid), 32'h0);
        cyc();
        m1_req = 1'b0;
        @(negedge clk);
        check("t4_m1_rvalid", 32'(m1_rvalid), 32'h1);
        check("t4_m1_rdata", m1_rdata, 32'h12345555);
        check("t4_m0_rvalid_n2", 32'(m0_rvalid), 32'h0);
        check("t4_m0_rdata_n2", m0_rdata, 32'h0);
        cyc();

        // Idle with stale attributes: mux must stay at zero
        m0_we = 4'hF; m0_addr = 16'h0055; m0_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("idle_mem_en", 32'(mem_en), 32'h0);
        check("idle_mem_we", 32'(mem_we), 32'h0);
        check("idle_mem_addr", 32'(mem_addr), 32'h0);
        check("idle_mem_wdata", mem_wdata, 32'h0);
        cyc();

        // Continuous contention: 8 m0 grants then one m1 grant
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_we = 4'h0; m1_addr = 16'h0020;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("t2_m0_gnt_%0d", i), 32'(m0_gnt), 32'((i % 9) != 8));
            check($sformatf("t2_m1_gnt_%0d", i), 32'(m1_gnt), 32'((i % 9) == 8));
            cyc();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();
        cyc();

        // Reset the cycle after a read grant, with hold_cnt part-way up
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_pre_m0_gnt", 32'(m0_gnt), 32'h1);
            cyc();
        end
        m0_we = 4'hF;
        reset = 1'b1;
        #1;
        check("t5_m0_rvalid", 32'(m0_rvalid), 32'h0);
        check("t5_m0_rdata", m0_rdata, 32'h0);
        check("t5_m0_gnt", 32'(m0_gnt), 32'h0);
        check("t5_m1_gnt", 32'(m1_gnt), 32'h0);
        check("t5_mem_en", 32'(mem_en), 32'h0);
        check("t5_mem_we", 32'(mem_we), 32'h0);
        m0_we = 4'h0;
        cyc();
        reset = 1'b0;

        // 10 contended cycles from reset: hold count restarts at zero
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n0 += int'(m0_gnt);
            n1 += int'(m1_gnt);
            check($sformatf("t6_m1_gnt_%0d", i), 32'(m1_gnt), 32'(i == 8));
            cyc();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("t6_m0_total", 32'(n0), 32'd9);
        check("t6_m1_total", 32'(n1), 32'd1);
`ifdef ARB_STATS_EN
        check("st_conflict", stat_conflict_cnt, 32'd10);
        check("st_m1", stat_m1_cnt, 32'd1);
        check("st_sum", stat_m0_cnt + stat_m1_cnt, 32'd10);
`endif
        repeat (3) cyc();
        check("sb_q0_empty", 32'(q0.size()), 32'h0);
        check("sb_q1_empty", 32'(q1.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
